// File: rtl/logic_gate.sv
// Two-output registered boolean gate with per-combination truth-table capture.
// Each output applies its own selectable 2-input operation to in1/in2.
module logic_gate #(
    parameter logic [2:0] OP1_RST = 3'b000,
    parameter logic [2:0] OP2_RST = 3'b001
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in1,
    input  logic       in2,
    input  logic       en,
    input  logic [2:0] op1_sel,
    input  logic [2:0] op2_sel,
    input  logic       clr,
    output logic       out1,
    output logic       out2,
    output logic [3:0] tt1,
    output logic [3:0] tt2,
    output logic [3:0] tt_valid
);

    // The reset encodings only document bench defaults and never reach the datapath.
    logic unused_params_s;
    assign unused_params_s = ^{OP1_RST, OP2_RST};

    function automatic logic gate_eval(input logic [2:0] sel, input logic a, input logic b);
        logic r;
        case (sel)
            3'b000:  r = a & b;
            3'b001:  r = a | b;
            3'b010:  r = a ^ b;
            3'b011:  r = ~(a & b);
            3'b100:  r = ~(a | b);
            3'b101:  r = ~(a ^ b);
            3'b110:  r = ~a;
            3'b111:  r = a;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    logic       out1_d, out1_q;
    logic       out2_d, out2_q;
    logic [3:0] tt1_d, tt1_q;
    logic [3:0] tt2_d, tt2_q;
    logic [3:0] tt_valid_d, tt_valid_q;
    logic [1:0] idx_s;
    logic       res1_s, res2_s;

    // Next-state: clear wipes the capture first so a simultaneous enable still lands its entry.
    always_comb begin
        idx_s      = {in1, in2};
        res1_s     = gate_eval(op1_sel, in1, in2);
        res2_s     = gate_eval(op2_sel, in1, in2);
        out1_d     = out1_q;
        out2_d     = out2_q;
        tt1_d      = tt1_q;
        tt2_d      = tt2_q;
        tt_valid_d = tt_valid_q;
        if (clr) begin
            tt1_d      = 4'h0;
            tt2_d      = 4'h0;
            tt_valid_d = 4'h0;
        end else begin
            tt1_d      = tt1_q;
            tt2_d      = tt2_q;
            tt_valid_d = tt_valid_q;
        end
        if (en) begin
            out1_d            = res1_s;
            out2_d            = res2_s;
            tt1_d[idx_s]      = res1_s;
            tt2_d[idx_s]      = res2_s;
            tt_valid_d[idx_s] = 1'b1;
        end else begin
            out1_d = out1_q;
            out2_d = out2_q;
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out1_q     <= 1'b0;
            out2_q     <= 1'b0;
            tt1_q      <= 4'h0;
            tt2_q      <= 4'h0;
            tt_valid_q <= 4'h0;
        end else begin
            out1_q     <= out1_d;
            out2_q     <= out2_d;
            tt1_q      <= tt1_d;
            tt2_q      <= tt2_d;
            tt_valid_q <= tt_valid_d;
        end
    end

    assign out1     = out1_q;
    assign out2     = out2_q;
    assign tt1      = tt1_q;
    assign tt2      = tt2_q;
    assign tt_valid = tt_valid_q;

endmodule

// File: tb/tb_logic_gate.sv
// Directed self-checking bench for logic_gate: sweeps, hold, clear and reset behaviour.
module tb_logic_gate;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in1 = 1'b0;
    logic       in2 = 1'b0;
    logic       en = 1'b0;
    logic [2:0] op1_sel = 3'b000;
    logic [2:0] op2_sel = 3'b001;
    logic       clr = 1'b0;
    logic       out1, out2;
    logic [3:0] tt1, tt2, tt_valid;

    int errors = 0;
    int checks = 0;

    logic_gate #(.OP1_RST(3'b000), .OP2_RST(3'b001)) dut (
        .clk(clk), .rst_n(rst_n), .in1(in1), .in2(in2), .en(en),
        .op1_sel(op1_sel), .op2_sel(op2_sel), .clr(clr),
        .out1(out1), .out2(out2), .tt1(tt1), .tt2(tt2), .tt_valid(tt_valid)
    );

    always #5 clk = ~clk;

    // Drive one cycle of inputs at the falling edge, then settle just past the rising edge.
    task automatic drive(input logic a, input logic b, input logic e, input logic c,
                         input logic [2:0] s1, input logic [2:0] s2);
        @(negedge clk);
        in1 = a; in2 = b; en = e; clr = c; op1_sel = s1; op2_sel = s2;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if ({out1, out2, tt1, tt2, tt_valid} !== 14'h0) begin
            $display("FAIL reset_state got=%h exp=0", {out1, out2, tt1, tt2, tt_valid});
            errors++;
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Apply all four combinations with en=1; per-step expected outputs are hand-computed.
    task automatic sweep(input string name, input logic [2:0] s1, input logic [2:0] s2,
                         input logic [3:0] exp1, input logic [3:0] exp2);
        for (int k = 0; k < 4; k++) begin
            logic [1:0] kk;
            kk = k[1:0];
            drive(kk[1], kk[0], 1'b1, 1'b0, s1, s2);
            checks++;
            if (out1 !== exp1[k] || out2 !== exp2[k]) begin
                $display("FAIL %s_step%0d out1/out2 got=%b%b exp=%b%b", name, k, out1, out2, exp1[k], exp2[k]);
                errors++;
            end
        end
        checks++;
        if (tt1 !== exp1 || tt2 !== exp2 || tt_valid !== 4'b1111) begin
            $display("FAIL %s_tt got tt1=%b tt2=%b v=%b exp tt1=%b tt2=%b v=1111", name, tt1, tt2, tt_valid, exp1, exp2);
            errors++;
        end
    endtask

    task automatic test_and_or();
        sweep("and_or", 3'b000, 3'b001, 4'b1000, 4'b1110);
    endtask

    task automatic test_xor_xnor();
        sweep("xor_xnor", 3'b010, 3'b101, 4'b0110, 4'b1001);
    endtask

    task automatic test_nand_nor_not_buf();
        sweep("nand_nor", 3'b011, 3'b100, 4'b0111, 4'b0001);
        sweep("not_buf", 3'b110, 3'b111, 4'b0011, 4'b1100);
    endtask

    // After the NOT/BUF sweep the last step was {1,1}: out1=0, out2=1.
    task automatic test_hold_and_clear();
        for (int i = 0; i < 5; i++) begin
            logic [2:0] s;
            s = 3'(i + 2);
            drive(i[0], ~i[0], 1'b0, 1'b0, s, ~s);
            checks++;
            if (out1 !== 1'b0 || out2 !== 1'b1 || tt1 !== 4'b0011 || tt2 !== 4'b1100 || tt_valid !== 4'b1111) begin
                $display("FAIL hold_cyc%0d got o=%b%b tt1=%b tt2=%b v=%b exp o=01 tt1=0011 tt2=1100 v=1111",
                         i, out1, out2, tt1, tt2, tt_valid);
                errors++;
            end
        end
        drive(1'b1, 1'b1, 1'b0, 1'b1, 3'b000, 3'b000);
        checks++;
        if (out1 !== 1'b0 || out2 !== 1'b1 || tt1 !== 4'h0 || tt2 !== 4'h0 || tt_valid !== 4'h0) begin
            $display("FAIL clear_no_en got o=%b%b tt1=%b tt2=%b v=%b exp o=01 all tt 0",
                     out1, out2, tt1, tt2, tt_valid);
            errors++;
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 3'b001);
    endtask

    task automatic test_reset_midsweep();
        drive(1'b1, 1'b1, 1'b1, 1'b0, 3'b000, 3'b001);
        drive(1'b0, 1'b1, 1'b1, 1'b0, 3'b000, 3'b001);
        checks++;
        if (out1 !== 1'b0 || out2 !== 1'b1 || tt1 !== 4'b1000 || tt2 !== 4'b1010 || tt_valid !== 4'b1010) begin
            $display("FAIL two_captures got o=%b%b tt1=%b tt2=%b v=%b exp o=01 tt1=1000 tt2=1010 v=1010",
                     out1, out2, tt1, tt2, tt_valid);
            errors++;
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({out1, out2, tt1, tt2, tt_valid} !== 14'h0) begin
            $display("FAIL async_reset got=%h exp=0", {out1, out2, tt1, tt2, tt_valid});
            errors++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        en = 1'b0;
    endtask

    task automatic test_clear_with_enable();
        drive(1'b0, 1'b0, 1'b1, 1'b0, 3'b000, 3'b001);
        checks++;
        if (tt_valid !== 4'b0001 || out1 !== 1'b0 || out2 !== 1'b0) begin
            $display("FAIL post_reset_capture got v=%b o=%b%b exp v=0001 o=00", tt_valid, out1, out2);
            errors++;
        end
        drive(1'b1, 1'b1, 1'b1, 1'b1, 3'b000, 3'b001);
        checks++;
        if (tt_valid !== 4'b1000 || tt1 !== 4'b1000 || tt2 !== 4'b1000 || out1 !== 1'b1 || out2 !== 1'b1) begin
            $display("FAIL clear_with_en got v=%b tt1=%b tt2=%b o=%b%b exp v=1000 tt1=1000 tt2=1000 o=11",
                     tt_valid, tt1, tt2, out1, out2);
            errors++;
        end
    endtask

    initial begin
        test_reset();
        test_and_or();
        test_xor_xnor();
        test_nand_nor_not_buf();
        test_hold_and_clear();
        test_reset_midsweep();
        test_clear_with_enable();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
